// File: rtl/eim_bus_frontend.sv
// eim_bus_frontend: synchronizes asynchronous EIM bus pins and turns CPU cycles into
// single-cycle write strobes and read requests, stretching reads with wait and a timeout.
module eim_bus_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int RD_TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              eim_cs0_n,
    input  logic              eim_lba_n,
    input  logic              eim_wr_n,
    input  logic              eim_oe_n,
    input  logic [ADDR_W-1:0] da_in,
    output logic [DATA_W-1:0] da_out,
    output logic              da_oe,
    output logic              eim_wait_n,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              rd_req,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_ack,
    output logic              err_timeout
);
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, WR_HOLD, RD_WAIT, RD_DRIVE} state_t;

    logic [SYNC_STAGES-1:0][3:0]        strb_q, strb_d;
    logic [SYNC_STAGES-1:0][ADDR_W-1:0] da_q, da_d;
    logic [1:0]                         prev_q, prev_d;
    state_t                             state_q, state_d;
    logic [ADDR_W-1:0]                  addr_q, addr_d;
    logic [DATA_W-1:0]                  wdata_q, wdata_d, dout_q, dout_d;
    logic                               da_oe_q, da_oe_d, wr_en_q, wr_en_d, rd_req_q, rd_req_d;
    logic                               wait_n_q, wait_n_d, err_q, err_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [3:0]                         strb_s;
    logic [ADDR_W-1:0]                  da_s;
    logic                               cs_s, lba_s, wr_s, oe_s, lba_rise, wr_rise;

    assign strb_s   = strb_q[SYNC_STAGES-1];
    assign da_s     = da_q[SYNC_STAGES-1];
    assign cs_s     = strb_s[0];
    assign lba_s    = strb_s[1];
    assign wr_s     = strb_s[2];
    assign oe_s     = strb_s[3];
    assign lba_rise = lba_s & ~prev_q[0];
    assign wr_rise  = wr_s & ~prev_q[1];

    always_comb begin
        strb_d = {strb_q[SYNC_STAGES-2:0], {eim_oe_n, eim_wr_n, eim_lba_n, eim_cs0_n}};
        da_d   = {da_q[SYNC_STAGES-2:0], da_in};
        prev_d = {wr_s, lba_s};
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        dout_d   = dout_q;
        da_oe_d  = da_oe_q;
        wr_en_d  = 1'b0;
        rd_req_d = 1'b0;
        wait_n_d = wait_n_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        // Deselect wins over everything and discards any half-finished cycle.
        if (state_q != IDLE && cs_s) begin
            state_d  = IDLE;
            da_oe_d  = 1'b0;
            wait_n_d = 1'b1;
            cnt_d    = '0;
        end else begin
            case (state_q)
                IDLE: if (!cs_s && !lba_s) begin
                    state_d = ADDR;
                    addr_d  = da_s;
                end
                ADDR: if (lba_rise) state_d = DATA;
                      else if (!lba_s) addr_d = da_s;
                DATA: if (!wr_s) begin
                    state_d = WR_HOLD;
                    wdata_d = da_s[DATA_W-1:0];
                end else if (!oe_s) begin
                    state_d  = RD_WAIT;
                    rd_req_d = 1'b1;
                    wait_n_d = 1'b0;
                    cnt_d    = '0;
                end
                WR_HOLD: if (wr_rise) begin
                    wr_en_d = 1'b1;
                    state_d = IDLE;
                end else if (!wr_s) wdata_d = da_s[DATA_W-1:0];
                RD_WAIT: if (rd_ack) begin
                    dout_d   = rd_data;
                    wait_n_d = 1'b1;
                    da_oe_d  = !oe_s;
                    state_d  = RD_DRIVE;
                end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    dout_d   = '1;
                    err_d    = 1'b1;
                    wait_n_d = 1'b1;
                    da_oe_d  = !oe_s;
                    state_d  = RD_DRIVE;
                end else cnt_d = cnt_q + CNT_W'(1);
                RD_DRIVE: if (oe_s) begin
                    state_d = IDLE;
                    da_oe_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_q   <= '1;
            da_q     <= '0;
            prev_q   <= '1;
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            dout_q   <= '0;
            da_oe_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_req_q <= 1'b0;
            wait_n_q <= 1'b1;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            strb_q   <= strb_d;
            da_q     <= da_d;
            prev_q   <= prev_d;
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            dout_q   <= dout_d;
            da_oe_q  <= da_oe_d;
            wr_en_q  <= wr_en_d;
            rd_req_q <= rd_req_d;
            wait_n_q <= wait_n_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign da_out      = dout_q;
    assign da_oe       = da_oe_q;
    assign eim_wait_n  = wait_n_q;
    assign bus_addr    = addr_q;
    assign wr_data     = wdata_q;
    assign wr_en       = wr_en_q;
    assign rd_req      = rd_req_q;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_eim_bus_frontend.sv
// tb_eim_bus_frontend: directed EIM write, read, timeout, abort, collision and reset cycles.
module tb_eim_bus_frontend;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b1, lba = 1'b1, wr = 1'b1, oe = 1'b1;
    logic [7:0] da = '0, rdat = '0;
    logic       ack = 1'b0;
    logic [7:0] da_out, bus_addr, wr_data;
    logic       da_oe, wait_n, wr_en, rd_req, err;
    int         total = 0, bad = 0;
    int         n_wr = 0, n_rd = 0, n_both = 0, n_wait = 0;
    logic [7:0] last_addr = '0, last_wdata = '0;
    int         s_wr, s_rd, s_wait;
    logic       ok;

    eim_bus_frontend dut (
        .clk(clk), .rst_n(rst_n), .eim_cs0_n(cs), .eim_lba_n(lba), .eim_wr_n(wr),
        .eim_oe_n(oe), .da_in(da), .da_out(da_out), .da_oe(da_oe), .eim_wait_n(wait_n),
        .bus_addr(bus_addr), .wr_data(wr_data), .wr_en(wr_en), .rd_req(rd_req),
        .rd_data(rdat), .rd_ack(ack), .err_timeout(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            n_wr++;
            last_addr  = bus_addr;
            last_wdata = wr_data;
        end
        if (rd_req) n_rd++;
        if (wr_en && rd_req) n_both++;
        if (!wait_n) n_wait++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_wr = n_wr;
        s_rd = n_rd;
        s_wait = n_wait;
    endtask

    task automatic addr_phase(input logic [7:0] a);
        cs = 1'b0; lba = 1'b0; da = a;
        hold(4);
        lba = 1'b1;
        hold(4);
    endtask

    task automatic idle_pins();
        cs = 1'b1; lba = 1'b1; wr = 1'b1; oe = 1'b1;
        hold(4);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        addr_phase(a);
        wr = 1'b0; da = d;
        hold(4);
        wr = 1'b1;
        hold(4);
        idle_pins();
    endtask

    task automatic wait_rd_req(output logic found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (rd_req) found = 1'b1;
        end
    endtask

    initial begin
        hold(2);
        chk("rst_wait_n", wait_n, 1);
        chk("rst_da_oe", da_oe, 0);
        chk("rst_strobes", {wr_en, rd_req}, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_dout", da_out, 0);
        chk("rst_wdata", wr_data, 0);
        rst_n = 1'b1;
        hold(4);

        snap();
        do_write(8'h05, 8'hA3);
        chk("wr_pulses", n_wr - s_wr, 1);
        chk("wr_addr", last_addr, 8'h05);
        chk("wr_data", last_wdata, 8'hA3);
        chk("wr_no_rd", n_rd - s_rd, 0);

        snap();
        addr_phase(8'h02);
        oe = 1'b0;
        wait_rd_req(ok);
        chk("rd_req_seen", ok, 1);
        chk("rd_req_addr", bus_addr, 8'h02);
        hold(3);
        ack = 1'b1; rdat = 8'h5C;
        hold(1);
        ack = 1'b0; rdat = 8'h00;
        hold(3);
        chk("rd_dout", da_out, 8'h5C);
        chk("rd_da_oe", da_oe, 1);
        chk("rd_wait_rel", wait_n, 1);
        oe = 1'b1;
        hold(5);
        chk("rd_oe_drop", da_oe, 0);
        idle_pins();
        chk("rd_wait_cycles", n_wait - s_wait, 4);
        chk("rd_pulses", n_rd - s_rd, 1);
        chk("rd_no_wr", n_wr - s_wr, 0);
        chk("rd_no_err", err, 0);

        snap();
        addr_phase(8'h10);
        oe = 1'b0;
        wait_rd_req(ok);
        chk("to_req_seen", ok, 1);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (wait_n) ok = 1'b1;
        end
        chk("to_released", ok, 1);
        chk("to_wait_cycles", n_wait - s_wait, 255);
        chk("to_dout", da_out, 8'hFF);
        chk("to_err", err, 1);
        chk("to_da_oe", da_oe, 1);
        idle_pins();

        snap();
        do_write(8'h33, 8'h7E);
        chk("err_sticky", err, 1);
        chk("wr2_data", last_wdata, 8'h7E);
        chk("wr2_addr", last_addr, 8'h33);

        snap();
        addr_phase(8'h44);
        wr = 1'b0; da = 8'h11;
        hold(4);
        cs = 1'b1;
        hold(4);
        wr = 1'b1;
        hold(6);
        chk("ab_no_wr", n_wr - s_wr, 0);
        chk("ab_wait_n", wait_n, 1);
        chk("ab_da_oe", da_oe, 0);
        idle_pins();

        snap();
        addr_phase(8'h21);
        wr = 1'b0; oe = 1'b0; da = 8'h9C;
        hold(4);
        wr = 1'b1; oe = 1'b1;
        hold(4);
        idle_pins();
        chk("col_wr", n_wr - s_wr, 1);
        chk("col_data", last_wdata, 8'h9C);
        chk("col_no_rd", n_rd - s_rd, 0);
        chk("col_wait_n", n_wait - s_wait, 0);

        addr_phase(8'h07);
        oe = 1'b0;
        wait_rd_req(ok);
        chk("rs_req_seen", ok, 1);
        hold(2);
        chk("rs_wait_low", wait_n, 0);
        rst_n = 1'b0;
        #1;
        chk("rs_wait_n", wait_n, 1);
        chk("rs_da_oe", da_oe, 0);
        chk("rs_err", err, 0);
        hold(3);
        cs = 1'b1; lba = 1'b1; oe = 1'b1;
        snap();
        hold(2);
        rst_n = 1'b1;
        hold(10);
        chk("rs_no_wr", n_wr - s_wr, 0);
        chk("rs_no_rd", n_rd - s_rd, 0);
        chk("rs_addr", bus_addr, 0);
        chk("both_never", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
